// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared types and constants for the 4x4 keypad scanner.
//  Revision : 1.0  initial release
// ============================================================================
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    localparam int          NUM_ROWS  = 4;
    localparam int          NUM_COLS  = 4;
    localparam logic [3:0]  ROWS_IDLE = 4'b1111;

    // Lowest-index row that is pulled low; 0 when no row is low.
    function automatic logic [1:0] lowest_low(input logic [NUM_ROWS-1:0] rows_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows_n[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_tick_sync.sv
`default_nettype none
// ============================================================================
//  Module   : tick_sync
//  Purpose  : Two-flop synchroniser plus rising-edge detect, 1-cycle tick out.
//  Revision : 1.0  initial release
// ============================================================================
module tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_tick
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_tick = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scanner
//  Purpose  : 4x4 active-low keypad scan with press/release debounce.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                scan_clk,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_out,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic                key_held
);

    localparam int            CW        = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] c_cnt_max = CW'(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] c_cnt_one = CW'(1);

    logic                w_tick;
    logic [NUM_ROWS-1:0] r_row_meta;
    logic [NUM_ROWS-1:0] r_row_sync;
    scan_state_t         r_state;
    logic [1:0]          r_col_idx;
    logic [1:0]          r_row_idx;
    logic [CW-1:0]       r_cnt;
    logic [3:0]          r_key_code;
    logic                r_key_valid;
    logic                r_key_held;

    logic                w_any_low;
    logic                w_row_low;
    logic [1:0]          w_first;
    logic [CW-1:0]       w_cnt_inc;

    tick_sync u_scan_tick (
        .clk     (clk_in),
        .rst     (rst),
        .i_async (scan_clk),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_row_meta <= ROWS_IDLE;
            r_row_sync <= ROWS_IDLE;
        end else begin
            r_row_meta <= row_in;
            r_row_sync <= r_row_meta;
        end
    end

    assign w_any_low = (r_row_sync != ROWS_IDLE);
    assign w_row_low = ~r_row_sync[r_row_idx];
    assign w_first   = lowest_low(r_row_sync);
    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_one;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state     <= SCAN;
            r_col_idx   <= 2'd0;
            r_row_idx   <= 2'd0;
            r_cnt       <= '0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    SCAN: begin
                        if (!w_any_low) begin
                            r_col_idx <= r_col_idx + 2'd1;
                        end else begin
                            r_row_idx <= w_first;
                            // A single-tick debounce accepts on the detecting tick.
                            if (c_cnt_max == c_cnt_one) begin
                                r_key_code  <= {w_first, r_col_idx};
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                                r_cnt       <= '0;
                                r_state     <= HELD;
                            end else begin
                                r_cnt   <= c_cnt_one;
                                r_state <= DEBOUNCE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (w_row_low) begin
                            if (w_cnt_inc == c_cnt_max) begin
                                r_key_code  <= {r_row_idx, r_col_idx};
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                                r_cnt       <= '0;
                                r_state     <= HELD;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_cnt     <= '0;
                            r_col_idx <= r_col_idx + 2'd1;
                            r_state   <= SCAN;
                        end
                    end
                    HELD: begin
                        if (!w_row_low) begin
                            if (c_cnt_max == c_cnt_one) begin
                                r_key_held <= 1'b0;
                                r_cnt      <= '0;
                                r_col_idx  <= r_col_idx + 2'd1;
                                r_state    <= SCAN;
                            end else begin
                                r_cnt   <= c_cnt_one;
                                r_state <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (!w_row_low) begin
                            if (w_cnt_inc == c_cnt_max) begin
                                r_key_held <= 1'b0;
                                r_cnt      <= '0;
                                r_col_idx  <= r_col_idx + 2'd1;
                                r_state    <= SCAN;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_cnt   <= '0;
                            r_state <= HELD;
                        end
                    end
                    default: r_state <= SCAN;
                endcase
            end
        end
    end

    assign col_out   = ~(4'b0001 << r_col_idx);
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scanner
//  Purpose  : Self-checking bench for keypad_scanner with a tick-level keypad model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int D      = 4;
    localparam int P_SCAN = 0;
    localparam int P_DEB  = 1;
    localparam int P_HELD = 2;
    localparam int P_REL  = 3;

    logic        clk_in   = 1'b0;
    logic        rst      = 1'b1;
    logic        scan_clk = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys     = 16'h0000;   // bit r*4+c set = key at row r, column c pressed

    int          n_checks  = 0;
    int          n_fail    = 0;
    int          pulse_cnt = 0;

    int          m_col, m_row, m_phase, m_n, m_pulses;
    logic [3:0]  m_code;
    logic        m_held;

    keypad_scanner #(.DEBOUNCE_TICKS(D)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .scan_clk  (scan_clk),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk_in = ~clk_in;

    // Physical keypad: a pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && (col_out[c] === 1'b0)) row_in[r] = 1'b0;
    end

    always @(negedge clk_in) if (key_valid === 1'b1) pulse_cnt++;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [3:0] exp_col();
        return ~(4'b0001 << m_col);
    endfunction

    task automatic model_accept();
        m_code = 4'(m_row * 4 + m_col);
        m_held = 1'b1;
        m_pulses++;
        m_phase = P_HELD;
    endtask

    task automatic model_release();
        m_held  = 1'b0;
        m_col   = (m_col + 1) % 4;
        m_phase = P_SCAN;
    endtask

    // One scan step as seen by the keypad, given which keys are held during it.
    task automatic model_tick(input logic [15:0] k);
        int first;
        bit down;
        first = -1;
        for (int r = 3; r >= 0; r--) if (k[r*4+m_col]) first = r;
        down = k[m_row*4+m_col];
        case (m_phase)
            P_SCAN: if (first < 0) m_col = (m_col + 1) % 4;
                    else begin
                        m_row = first; m_n = 1;
                        if (m_n >= D) model_accept(); else m_phase = P_DEB;
                    end
            P_DEB:  if (down) begin
                        m_n++;
                        if (m_n >= D) model_accept();
                    end else begin
                        m_col = (m_col + 1) % 4; m_phase = P_SCAN;
                    end
            P_HELD: if (!down) begin
                        m_n = 1;
                        if (m_n >= D) model_release(); else m_phase = P_REL;
                    end
            default: if (!down) begin
                        m_n++;
                        if (m_n >= D) model_release();
                    end else m_phase = P_HELD;
        endcase
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk_in);
        rst = 1'b1;
        repeat (cycles) @(negedge clk_in);
        rst = 1'b0;
        m_col = 0; m_row = 0; m_phase = P_SCAN; m_n = 0; m_code = 4'd0; m_held = 1'b0;
    endtask

    // One scan_clk period of 20 clk_in cycles with a fixed key set.
    task automatic do_tick(input logic [15:0] k);
        keys = k;
        repeat (5) @(negedge clk_in);
        scan_clk = 1'b1;
        model_tick(k);
        repeat (10) @(negedge clk_in);
        scan_clk = 1'b0;
        repeat (5) @(negedge clk_in);
    endtask

    task automatic test_reset();
        m_pulses = pulse_cnt;
        keys = 16'h0000;
        apply_reset(3);
        n_checks++; if (col_out !== 4'b1110) begin n_fail++; $display("FAIL reset_col: got %b want 1110", col_out); end
        n_checks++; if (key_code !== 4'd0) begin n_fail++; $display("FAIL reset_code: got %h want 0", key_code); end
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", key_valid); end
        n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL reset_held: got %b want 0", key_held); end
    endtask

    task automatic test_idle_scan();
        logic [3:0] seq [5];
        seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
        for (int i = 0; i < 5; i++) begin
            do_tick(16'h0000);
            n_checks++; if (col_out !== seq[i]) begin n_fail++; $display("FAIL idle_col[%0d]: got %b want %b", i, col_out, seq[i]); end
        end
        n_checks++; if (pulse_cnt != m_pulses) begin n_fail++; $display("FAIL idle_valid: got %0d pulses want %0d", pulse_cnt, m_pulses); end
    endtask

    task automatic test_clean_press();
        int base;
        apply_reset(3);
        base = pulse_cnt;
        for (int t = 1; t <= 16; t++) begin
            do_tick(t <= 11 ? 16'h0200 : 16'h0000);
            n_checks++; if (col_out !== exp_col() || key_held !== m_held || key_code !== m_code)
                begin n_fail++; $display("FAIL press_model t=%0d: got col=%b held=%b code=%h want col=%b held=%b code=%h", t, col_out, key_held, key_code, exp_col(), m_held, m_code); end
            if (t == 4) begin n_checks++; if (pulse_cnt != base) begin n_fail++; $display("FAIL press_early: got %0d pulses want 0", pulse_cnt - base); end end
            if (t == 5) begin
                n_checks++; if (pulse_cnt != base + 1) begin n_fail++; $display("FAIL press_pulse: got %0d pulses want 1", pulse_cnt - base); end
                n_checks++; if (key_code !== 4'b1001) begin n_fail++; $display("FAIL press_code: got %b want 1001", key_code); end
            end
            if (t == 14) begin n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL press_held_early: got %b want 1", key_held); end end
            if (t == 15) begin n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL press_release: got %b want 0", key_held); end end
        end
        n_checks++; if (pulse_cnt != base + 1) begin n_fail++; $display("FAIL press_total: got %0d pulses want 1", pulse_cnt - base); end
        m_pulses = pulse_cnt;
    endtask

    task automatic test_bounce();
        int base;
        apply_reset(3);
        base = pulse_cnt;
        repeat (3) do_tick(16'h0000);
        do_tick(16'h0008);
        do_tick(16'h0008);
        do_tick(16'h0000);
        n_checks++; if (col_out !== 4'b1110 || key_held !== 1'b0 || pulse_cnt != base)
            begin n_fail++; $display("FAIL bounce_abort: got col=%b held=%b pulses=%0d want col=1110 held=0 pulses=0", col_out, key_held, pulse_cnt - base); end
        repeat (8) do_tick(16'h0008);
        n_checks++; if (key_code !== 4'b0011) begin n_fail++; $display("FAIL bounce_code: got %b want 0011", key_code); end
        n_checks++; if (pulse_cnt != base + 1) begin n_fail++; $display("FAIL bounce_pulse: got %0d pulses want 1", pulse_cnt - base); end
        n_checks++; if (key_held !== m_held || col_out !== exp_col())
            begin n_fail++; $display("FAIL bounce_model: got held=%b col=%b want held=%b col=%b", key_held, col_out, m_held, exp_col()); end
        m_pulses = pulse_cnt;
    endtask

    task automatic test_two_keys();
        int base;
        apply_reset(3);
        base = pulse_cnt;
        repeat (4) do_tick(16'h1010);
        n_checks++; if (key_code !== 4'b0100 || pulse_cnt != base + 1)
            begin n_fail++; $display("FAIL two_keys_code: got code=%b pulses=%0d want code=0100 pulses=1", key_code, pulse_cnt - base); end
        repeat (5) do_tick(16'h0010);
        n_checks++; if (key_held !== 1'b1 || col_out !== 4'b1110)
            begin n_fail++; $display("FAIL two_keys_held: got held=%b col=%b want held=1 col=1110", key_held, col_out); end
        repeat (4) do_tick(16'h0000);
        n_checks++; if (key_held !== 1'b0 || key_held !== m_held)
            begin n_fail++; $display("FAIL two_keys_release: got held=%b want 0", key_held); end
        m_pulses = pulse_cnt;
    endtask

    task automatic test_release_bounce();
        int base;
        apply_reset(3);
        base = pulse_cnt;
        repeat (4) do_tick(16'h0010);
        repeat (2) do_tick(16'h0000);
        do_tick(16'h0010);
        n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL relb_held: got %b want 1", key_held); end
        repeat (3) do_tick(16'h0010);
        n_checks++; if (pulse_cnt != base + 1 || key_held !== 1'b1)
            begin n_fail++; $display("FAIL relb_no_repeat: got pulses=%0d held=%b want pulses=1 held=1", pulse_cnt - base, key_held); end
        repeat (3) do_tick(16'h0000);
        n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL relb_restart: got %b want 1", key_held); end
        do_tick(16'h0000);
        n_checks++; if (key_held !== 1'b0 || col_out !== 4'b1101)
            begin n_fail++; $display("FAIL relb_release: got held=%b col=%b want held=0 col=1101", key_held, col_out); end
        m_pulses = pulse_cnt;
    endtask

    task automatic test_mid_reset();
        int base;
        apply_reset(3);
        base = pulse_cnt;
        repeat (2) do_tick(16'h0200);
        apply_reset(1);
        n_checks++; if (col_out !== 4'b1110 || key_held !== 1'b0 || key_code !== 4'd0 || key_valid !== 1'b0)
            begin n_fail++; $display("FAIL rst_deb: got col=%b held=%b code=%h valid=%b want 1110/0/0/0", col_out, key_held, key_code, key_valid); end
        repeat (5) do_tick(16'h0200);
        n_checks++; if (key_held !== 1'b1 || pulse_cnt != base + 1)
            begin n_fail++; $display("FAIL rst_reaccept: got held=%b pulses=%0d want held=1 pulses=1", key_held, pulse_cnt - base); end
        apply_reset(1);
        n_checks++; if (col_out !== 4'b1110 || key_held !== 1'b0 || key_code !== 4'd0 || key_valid !== 1'b0)
            begin n_fail++; $display("FAIL rst_held: got col=%b held=%b code=%h valid=%b want 1110/0/0/0", col_out, key_held, key_code, key_valid); end
        keys = 16'h0000;
        repeat (8) @(negedge clk_in);
        n_checks++; if (pulse_cnt != base + 1) begin n_fail++; $display("FAIL rst_no_pulse: got %0d pulses want 1", pulse_cnt - base); end
        m_pulses = pulse_cnt;
    endtask

    task automatic test_random();
        logic [15:0] k;
        int len;
        apply_reset(2);
        m_pulses = pulse_cnt;
        for (int b = 0; b < 60; b++) begin
            k = 16'h0000;
            case ($urandom_range(0, 3))
                0: k = 16'h0000;
                3: begin k[$urandom_range(0, 15)] = 1'b1; k[$urandom_range(0, 15)] = 1'b1; end
                default: k[$urandom_range(0, 15)] = 1'b1;
            endcase
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++) begin
                do_tick(k);
                n_checks++; if (col_out !== exp_col() || key_held !== m_held || key_code !== m_code || pulse_cnt != m_pulses)
                    begin n_fail++; $display("FAIL random b=%0d j=%0d: got col=%b held=%b code=%h pulses=%0d want col=%b held=%b code=%h pulses=%0d",
                                             b, j, col_out, key_held, key_code, pulse_cnt, exp_col(), m_held, m_code, m_pulses); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_clean_press();
        test_bounce();
        test_two_keys();
        test_release_bounce();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
